// File: rtl/ssd1306_rx.sv
// ssd1306_rx - receive side of the SSD1306 4-wire SPI link.
//
// Oversamples sclk/mosi/dc on the system clock, reassembles MSB-first bytes,
// decodes the command subset used by our OLED driver, and turns display-data
// bytes into framebuffer writes at the current {page, col} pointer.
//
// Optional feature macro: SSD1306_RX_REMAP_EN
//   defined   : col_remap = 1 mirrors the write column (fb_addr[6:0] = 127 - col)
//   undefined : col_remap is decoded and reported only
//
// Ports:
//   clk, rst            system clock (>= 4x sclk), synchronous active-high reset
//   sclk, mosi, dc      asynchronous SPI inputs (dc sampled with bit 0)
//   fb_we/addr/wdata    one-cycle write strobe, {page,col} address, pixel byte
//   frame_done          pulse on the write that wraps a horizontal-mode window
//   cmd_err             pulse on unknown opcode or command aborted by data
//   disp_on .. entire_on, contrast, addr_mode   decoded display state
module ssd1306_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int IDLE_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       dc,
    output logic       fb_we,
    output logic [9:0] fb_addr,
    output logic [7:0] fb_wdata,
    output logic       frame_done,
    output logic       cmd_err,
    output logic       disp_on,
    output logic       charge_pump,
    output logic       col_remap,
    output logic       com_rev,
    output logic       entire_on,
    output logic [7:0] contrast,
    output logic [1:0] addr_mode
);
    localparam int IW = $clog2(IDLE_CYCLES + 1);

    // ---------------- front end ----------------
    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, dc_sync;
    logic          sclk_prev;
    logic [6:0]    shreg;
    logic [2:0]    bit_cnt;
    logic [IW-1:0] idle_cnt;
    logic          byte_vld, byte_dc;
    logic [7:0]    byte_q;
    logic          sclk_s, mosi_s, dc_s, rise;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign dc_s   = dc_sync[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            dc_sync   <= '0;
            sclk_prev <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            idle_cnt  <= '0;
            byte_vld  <= 1'b0;
            byte_dc   <= 1'b0;
            byte_q    <= '0;
        end else begin
            sclk_sync[0] <= sclk;
            mosi_sync[0] <= mosi;
            dc_sync[0]   <= dc;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sclk_sync[i] <= sclk_sync[i-1];
                mosi_sync[i] <= mosi_sync[i-1];
                dc_sync[i]   <= dc_sync[i-1];
            end
            sclk_prev <= sclk_s;
            byte_vld  <= 1'b0;
            // An edge takes priority over an idle timeout in the same cycle.
            if (rise) begin
                idle_cnt <= '0;
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_q   <= {shreg, mosi_s};
                    byte_dc  <= dc_s;
                    byte_vld <= 1'b1;
                end else begin
                    shreg <= {shreg[5:0], mosi_s};
                end
            end else if (idle_cnt == IW'(IDLE_CYCLES)) begin
                bit_cnt <= '0;      // saturated: drop any partial byte
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    // ---------------- parser ----------------
    typedef enum logic [1:0] {OPC, ARG1, ARG2} state_t;
    state_t     state, state_n;
    logic [7:0] opcode, opcode_n;
    logic [6:0] col, col_n, col_start, col_start_n, col_end, col_end_n, col_phys;
    logic [2:0] page, page_n, page_start, page_start_n, page_end, page_end_n;
    logic       fb_we_n, frame_done_n, cmd_err_n;
    logic       disp_on_n, charge_pump_n, col_remap_n, com_rev_n, entire_on_n;
    logic [9:0] fb_addr_n;
    logic [7:0] fb_wdata_n, contrast_n;
    logic [1:0] addr_mode_n;

`ifdef SSD1306_RX_REMAP_EN
    assign col_phys = col_remap ? (7'd127 - col) : col;
`else
    assign col_phys = col;
`endif

    always_comb begin
        state_n       = state;
        opcode_n      = opcode;
        col_n         = col;
        col_start_n   = col_start;
        col_end_n     = col_end;
        page_n        = page;
        page_start_n  = page_start;
        page_end_n    = page_end;
        fb_we_n       = 1'b0;
        frame_done_n  = 1'b0;
        cmd_err_n     = 1'b0;
        fb_addr_n     = fb_addr;
        fb_wdata_n    = fb_wdata;
        disp_on_n     = disp_on;
        charge_pump_n = charge_pump;
        col_remap_n   = col_remap;
        com_rev_n     = com_rev;
        entire_on_n   = entire_on;
        contrast_n    = contrast;
        addr_mode_n   = addr_mode;
        if (byte_vld) begin
            if (byte_dc) begin
                // Data aborts any pending argument but is still written.
                if (state != OPC) begin
                    cmd_err_n = 1'b1;
                    state_n   = OPC;
                end
                fb_we_n    = 1'b1;
                fb_addr_n  = {page, col_phys};
                fb_wdata_n = byte_q;
                if (col != col_end) begin
                    col_n = col + 7'd1;
                end else begin
                    col_n = col_start;
                    if (addr_mode == 2'b00) begin
                        if (page == page_end) begin
                            page_n       = page_start;
                            frame_done_n = 1'b1;
                        end else begin
                            page_n = page + 3'd1;
                        end
                    end
                end
            end else begin
                unique case (state)
                    OPC: begin
                        opcode_n = byte_q;
                        case (byte_q)
                            8'h8D, 8'h20, 8'h81, 8'hD9,
                            8'h21, 8'h22: state_n = ARG1;
                            8'hAE: disp_on_n   = 1'b0;
                            8'hAF: disp_on_n   = 1'b1;
                            8'hA0: col_remap_n = 1'b0;
                            8'hA1: col_remap_n = 1'b1;
                            8'hC0: com_rev_n   = 1'b0;
                            8'hC8: com_rev_n   = 1'b1;
                            8'hA4: entire_on_n = 1'b0;
                            8'hA5: entire_on_n = 1'b1;
                            default: cmd_err_n = 1'b1;
                        endcase
                    end
                    ARG1: begin
                        state_n = OPC;
                        case (opcode)
                            8'h8D: charge_pump_n = byte_q[2];
                            8'h20: addr_mode_n   = byte_q[1:0];
                            8'h81: contrast_n    = byte_q;
                            8'h21: begin col_start_n  = byte_q[6:0]; state_n = ARG2; end
                            8'h22: begin page_start_n = byte_q[2:0]; state_n = ARG2; end
                            default: ;      // 0xD9 argument is ignored
                        endcase
                    end
                    ARG2: begin
                        state_n = OPC;
                        if (opcode == 8'h21) begin
                            col_end_n = byte_q[6:0];
                            col_n     = col_start;
                        end else begin
                            page_end_n = byte_q[2:0];
                            page_n     = page_start;
                        end
                    end
                    default: state_n = OPC;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= OPC;
            opcode      <= '0;
            col         <= '0;
            col_start   <= '0;
            col_end     <= 7'd127;
            page        <= '0;
            page_start  <= '0;
            page_end    <= 3'd7;
            fb_we       <= 1'b0;
            frame_done  <= 1'b0;
            cmd_err     <= 1'b0;
            fb_addr     <= '0;
            fb_wdata    <= '0;
            disp_on     <= 1'b0;
            charge_pump <= 1'b0;
            col_remap   <= 1'b0;
            com_rev     <= 1'b0;
            entire_on   <= 1'b0;
            contrast    <= 8'h7F;
            addr_mode   <= 2'b10;
        end else begin
            state       <= state_n;
            opcode      <= opcode_n;
            col         <= col_n;
            col_start   <= col_start_n;
            col_end     <= col_end_n;
            page        <= page_n;
            page_start  <= page_start_n;
            page_end    <= page_end_n;
            fb_we       <= fb_we_n;
            frame_done  <= frame_done_n;
            cmd_err     <= cmd_err_n;
            fb_addr     <= fb_addr_n;
            fb_wdata    <= fb_wdata_n;
            disp_on     <= disp_on_n;
            charge_pump <= charge_pump_n;
            col_remap   <= col_remap_n;
            com_rev     <= com_rev_n;
            entire_on   <= entire_on_n;
            contrast    <= contrast_n;
            addr_mode   <= addr_mode_n;
        end
    end
endmodule

// File: tb/tb_ssd1306_rx.sv
// Bench for ssd1306_rx: directed SPI command/data sequences; expected
// framebuffer writes go into a queue that a negedge monitor drains.
module tb_ssd1306_rx;
    localparam int SYNC_STAGES = 2;
    localparam int IDLE_CYCLES = 64;

    logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, mosi = 1'b0, dc = 1'b0;
    logic fb_we, frame_done, cmd_err, disp_on, charge_pump, col_remap, com_rev, entire_on;
    logic [9:0] fb_addr;
    logic [7:0] fb_wdata, contrast;
    logic [1:0] addr_mode;

    ssd1306_rx #(.SYNC_STAGES(SYNC_STAGES), .IDLE_CYCLES(IDLE_CYCLES)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .dc(dc),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
        .frame_done(frame_done), .cmd_err(cmd_err),
        .disp_on(disp_on), .charge_pump(charge_pump), .col_remap(col_remap),
        .com_rev(com_rev), .entire_on(entire_on),
        .contrast(contrast), .addr_mode(addr_mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] addr;
        logic [7:0] data;
        logic       fd;
    } wr_t;

    wr_t exp_q[$];
    wr_t e;
    int  checks = 0, failures = 0;
    int  cmd_err_hi = 0, fd_hi = 0;

    // Scoreboard monitor: every strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_err)    cmd_err_hi++;
            if (frame_done) fd_hi++;
            if (fb_we) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write: got addr=%0d data=%0h, expected no write", fb_addr, fb_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (fb_addr !== e.addr || fb_wdata !== e.data || frame_done !== e.fd) begin
                        failures++;
                        $display("FAIL fb_write: got addr=%0d data=%0h fd=%0b, expected addr=%0d data=%0h fd=%0b",
                                 fb_addr, fb_wdata, frame_done, e.addr, e.data, e.fd);
                    end
                end
            end else if (frame_done) begin
                checks++;
                failures++;
                $display("FAIL frame_done_no_write: got frame_done=1 without fb_we, expected 0");
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic d);
        mosi = b;
        dc   = d;
        repeat (2) @(posedge clk);
        #1 sclk = 1'b1;
        repeat (2) @(posedge clk);
        #1 sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic d);
        for (int i = 7; i >= 0; i--) send_bit(b[i], d);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        send_byte(b, 1'b0);
    endtask

    task automatic send_data(input logic [7:0] b, input logic [9:0] addr, input logic fd);
        exp_q.push_back('{addr, b, fd});
        send_byte(b, 1'b1);
    endtask

    logic [7:0] byte_v;
    logic [9:0] remap_addr;
    logic [9:0] sv_addr;
    logic [7:0] sv_data, sv_con;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_fb_we", fb_we, 0);
        chk("rst_fb_addr", fb_addr, 0);
        chk("rst_contrast", contrast, 8'h7F);
        chk("rst_addr_mode", addr_mode, 2'b10);
        chk("rst_disp_on", disp_on, 0);
        @(posedge clk);
        #1;

        // 0xAF with latency measured from the raw 8th sclk edge
        byte_v = 8'hAF;
        for (int i = 7; i >= 1; i--) send_bit(byte_v[i], 1'b0);
        mosi = byte_v[0];
        repeat (2) @(posedge clk);
        #1 sclk = 1'b1;
        repeat (SYNC_STAGES + 1) @(posedge clk);
        @(negedge clk) chk("disp_on_early", disp_on, 0);
        @(posedge clk);
        @(negedge clk) chk("disp_on_latency", disp_on, 1);
        @(posedge clk);
        #1 sclk = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // contrast, then a command aborted by data
        send_cmd(8'h81); send_cmd(8'hCF);
        chk("contrast_cf", contrast, 8'hCF);
        chk("no_err_yet", cmd_err_hi, 0);
        send_cmd(8'h81);
        send_data(8'h55, 10'd0, 1'b0);
        chk("abort_err_pulse", cmd_err_hi, 1);
        chk("abort_contrast", contrast, 8'hCF);

        // full-screen horizontal window, 1025 bytes
        send_cmd(8'h20); send_cmd(8'h00);
        send_cmd(8'h21); send_cmd(8'h00); send_cmd(8'h7F);
        send_cmd(8'h22); send_cmd(8'h00); send_cmd(8'hFF);
        chk("addr_mode_h", addr_mode, 2'b00);
        for (int i = 0; i < 1025; i++)
            send_data(8'(i), 10'(i % 1024), i == 1023);
        chk("frame_done_count", fd_hi, 1);

        // narrow column window wraps into the next page
        send_cmd(8'h21); send_cmd(8'h10); send_cmd(8'h11);
        send_data(8'hAA, 10'd16, 1'b0);
        send_data(8'hBB, 10'd17, 1'b0);
        send_data(8'hCC, 10'd144, 1'b0);

        // partial byte discarded by idle timeout
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        repeat (IDLE_CYCLES + 5) @(posedge clk);
        #1;
        send_cmd(8'hA1);
        chk("remap_after_idle", col_remap, 1);
        chk("idle_no_err", cmd_err_hi, 1);
        send_cmd(8'h21); send_cmd(8'h00); send_cmd(8'h7F);
`ifdef SSD1306_RX_REMAP_EN
        remap_addr = 10'd255;
`else
        remap_addr = 10'd128;
`endif
        send_data(8'h3C, remap_addr, 1'b0);

        // misc decoded state
        send_cmd(8'hC8); send_cmd(8'hA5);
        send_cmd(8'h8D); send_cmd(8'h14);
        send_cmd(8'hD9); send_cmd(8'hF1);
        send_cmd(8'hAE);
        chk("com_rev", com_rev, 1);
        chk("entire_on", entire_on, 1);
        chk("charge_pump", charge_pump, 1);
        chk("disp_off_after_d9", disp_on, 0);
        chk("misc_no_err", cmd_err_hi, 1);

        // unknown opcode: one-cycle error, nothing else moves
        sv_addr = fb_addr; sv_data = fb_wdata; sv_con = contrast;
        send_cmd(8'hE3);
        chk("e3_err_one_cycle", cmd_err_hi, 2);
        chk("e3_fb_addr_hold", fb_addr, sv_addr);
        chk("e3_fb_wdata_hold", fb_wdata, sv_data);
        chk("e3_contrast", contrast, sv_con);
        chk("e3_state", {disp_on, charge_pump, col_remap, com_rev, entire_on, addr_mode}, 7'b0111100);

        // reset mid-byte
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_contrast", contrast, 8'h7F);
        chk("mid_rst_state", {fb_we, cmd_err, disp_on, charge_pump, col_remap, com_rev, entire_on, addr_mode}, 9'b000000010);
        @(posedge clk);
        #1;
        send_cmd(8'hAF);
        chk("post_rst_aligned", disp_on, 1);
        chk("post_rst_no_err", cmd_err_hi, 2);

        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
